// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder arbiter: tag type, index width and
// the round-robin search used to pick the next requester.
package adder_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int TAG_W   = 4;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic found;
    tag_t idx;
  } pick_t;

  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First valid requester at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input tag_t ptr, input int n);
    pick_t res;
    int    c;
    res = '{found: 1'b0, idx: tag_t'(0)};
    for (int k = 0; k < MAX_REQ; k++) begin
      c   = (int'(ptr) + k >= n) ? int'(ptr) + k - n : int'(ptr) + k;
      res = (k < n && !res.found && valid[c[3:0]]) ? '{found: 1'b1, idx: tag_t'(c)} : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_arb_tag_fifo.sv
// Tag FIFO remembering which requester issued each in-flight adder operation.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module adder_arb_tag_fifo
  import adder_arb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  tag_t             push_tag,
  input  logic             pop,
  output tag_t             head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == CNT_W'(0));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Tag storage, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CNT_W'(0);
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? AW'(0) : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? AW'(0) : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin, credit-limited arbiter sharing one pipelined adder between
// NUM_REQ requesters. Define ADDER_ARB_STATS_EN to add grant/stall counters.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int BITS         = 16,
  parameter  int NUM          = 4,
  parameter  int MAX_INFLIGHT = 8,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*NUM*BITS-1:0] req_data,
  output logic                        add_valid,
  output logic [NUM*BITS-1:0]         add_data,
  input  logic                        add_valid_out,
  input  logic [BITS-1:0]             add_o,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [BITS-1:0]             rsp_data,
  output logic [CNT_W-1:0]            inflight,
  output logic                        err_orphan
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_grants,
  output logic [31:0]                 stat_stalls
`endif
);

  localparam int REQ_IDX_W = req_idx_w(NUM_REQ);

  logic [REQ_IDX_W-1:0] rr;
  logic [MAX_REQ-1:0]   valid_ext;
  pick_t                pick;
  logic                 credit_ok;
  logic                 grant;
  logic                 pop;
  logic                 orphan;
  tag_t                 head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [NUM*BITS-1:0]  issue_data;

  // Widen the request vector to the search function's fixed width.
  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = req_valid;
  end

  // A returning result frees its slot in the same cycle, so a full FIFO can still grant.
  assign pick      = rr_pick(valid_ext, tag_t'(rr), NUM_REQ);
  assign credit_ok = !fifo_full || add_valid_out;
  assign grant     = resetn && credit_ok && pick.found;
  assign pop       = add_valid_out && !fifo_empty;
  assign orphan    = add_valid_out && fifo_empty;
  assign rsp_data  = add_o;

  // One-hot grant and response strobes plus the winner's operand slice.
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    issue_data = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_ready[r] = grant && (pick.idx == tag_t'(r));
      rsp_valid[r] = resetn && pop && (head == tag_t'(r));
      issue_data   = (pick.idx == tag_t'(r)) ? req_data[r*NUM*BITS +: NUM*BITS] : issue_data;
    end
  end

  adder_arb_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (grant),
    .push_tag (pick.idx),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (inflight)
  );

  // Issue register towards the adder and round-robin pointer update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      add_valid <= 1'b0;
      add_data  <= '0;
      rr        <= REQ_IDX_W'(0);
    end else begin
      add_valid <= grant;
      if (grant) begin
        add_data <= issue_data;
        rr       <= (pick.idx == tag_t'(NUM_REQ - 1)) ? REQ_IDX_W'(0)
                                                      : REQ_IDX_W'(pick.idx + tag_t'(1));
      end else begin
        add_data <= add_data;
        rr       <= rr;
      end
    end
  end

  // Sticky flag for a result with no matching tag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_orphan <= 1'b0;
    end else if (orphan) begin
      err_orphan <= 1'b1;
    end else begin
      err_orphan <= err_orphan;
    end
  end

`ifdef ADDER_ARB_STATS_EN
  // Handshake and credit-stall counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_grants <= 32'd0;
      stat_stalls <= 32'd0;
    end else begin
      if (grant) begin
        stat_grants <= stat_grants + 32'd1;
      end
      if (|req_valid && !grant) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized bench: two arbiters (credit 8 and credit 2) share stimulus and are
// checked each cycle against a queue-based model; each drives a 3-cycle adder model.
module tb_adder_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [3:0]    req_valid;
  logic [255:0]  req_data;
  logic          inj;

  logic [3:0]  rdy_a, rdy_b, rsp_a, rsp_b;
  logic        av_a, av_b, err_a, err_b;
  logic [63:0] ad_a, ad_b;
  logic [15:0] rd_a, rd_b;
  logic [3:0]  infl_a;
  logic [1:0]  infl_b;
  logic [31:0] sg_a, sg_b, ss_a, ss_b;

  logic [3:0]  rdy [2], rsp [2], infl [2];
  logic        av [2], avo [2], err [2];
  logic [63:0] ad [2];
  logic [15:0] rd [2], ao [2];
  logic [31:0] sg [2], ss [2];

  logic [2:0]  pv [2];
  logic [15:0] pd [2][3];

  int          ops [4][4];
  int          n_vec = 0;
  int          n_bad = 0;

  int          m_tag [2][16];
  logic [15:0] m_res [2][16];
  int          m_head [2], m_cnt [2], m_rr [2], m_gr [2], m_st [2];
  logic        m_av [2], m_err [2];
  logic [63:0] m_ad [2];

  always #5 clk = ~clk;

  adder_arbiter #(.MAX_INFLIGHT(8)) dut_a (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(rdy_a), .req_data(req_data),
    .add_valid(av_a), .add_data(ad_a), .add_valid_out(avo[0]), .add_o(ao[0]),
    .rsp_valid(rsp_a), .rsp_data(rd_a), .inflight(infl_a), .err_orphan(err_a)
`ifdef ADDER_ARB_STATS_EN
    , .stat_grants(sg_a), .stat_stalls(ss_a)
`endif
  );

  adder_arbiter #(.MAX_INFLIGHT(2)) dut_b (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(rdy_b), .req_data(req_data),
    .add_valid(av_b), .add_data(ad_b), .add_valid_out(avo[1]), .add_o(ao[1]),
    .rsp_valid(rsp_b), .rsp_data(rd_b), .inflight(infl_b), .err_orphan(err_b)
`ifdef ADDER_ARB_STATS_EN
    , .stat_grants(sg_b), .stat_stalls(ss_b)
`endif
  );

`ifndef ADDER_ARB_STATS_EN
  assign sg_a = 32'd0;
  assign sg_b = 32'd0;
  assign ss_a = 32'd0;
  assign ss_b = 32'd0;
`endif

  always_comb begin
    rdy[0] = rdy_a;  rdy[1] = rdy_b;
    rsp[0] = rsp_a;  rsp[1] = rsp_b;
    av[0]  = av_a;   av[1]  = av_b;
    ad[0]  = ad_a;   ad[1]  = ad_b;
    rd[0]  = rd_a;   rd[1]  = rd_b;
    err[0] = err_a;  err[1] = err_b;
    infl[0] = infl_a;
    infl[1] = {2'b00, infl_b};
    sg[0] = sg_a;  sg[1] = sg_b;
    ss[0] = ss_a;  ss[1] = ss_b;
    for (int k = 0; k < 2; k++) begin
      avo[k] = pv[k][2] | inj;
      ao[k]  = pd[k][2];
    end
  end

  function automatic logic [15:0] to_fp16(input int v);
    int p;
    logic [15:0] h;
    if (v == 0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 16; i++) if ((v >> i) != 0) p = i;
    h = {1'b0, 5'(p + 15), 10'((v << 10) >> p)};
    return h;
  endfunction

  function automatic int from_fp16(input logic [15:0] h);
    longint t;
    if (h == 16'h0000) return 0;
    t = longint'({1'b1, h[9:0]}) << h[14:10];
    return int'(t >> 25);
  endfunction

  function automatic logic [15:0] adder_fn(input logic [63:0] d);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += from_fp16(d[i*16 +: 16]);
    return to_fp16(s);
  endfunction

  // 3-cycle FP16 adder model per instance; shares resetn with the arbiters.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pv[0] <= 3'b000;
      pv[1] <= 3'b000;
    end else begin
      for (int k = 0; k < 2; k++) begin
        pv[k]    <= {pv[k][1:0], av[k]};
        pd[k][0] <= adder_fn(ad[k]);
        pd[k][1] <= pd[k][0];
        pd[k][2] <= pd[k][1];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_data();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++) begin
        ops[r][i] = int'($urandom_range(0, 15));
        req_data[r*DW + (3-i)*16 +: 16] = to_fp16(ops[r][i]);
      end
  endtask

  function automatic int mi(input int k);
    return (k == 0) ? 8 : 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_head[k] = 0; m_cnt[k] = 0; m_rr[k] = 0; m_gr[k] = 0; m_st[k] = 0;
      m_av[k] = 1'b0; m_err[k] = 1'b0; m_ad[k] = 64'd0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_ready%0d", k), 64'(rdy[k]), 64'd0);
      check_eq($sformatf("rst_rsp%0d", k), 64'(rsp[k]), 64'd0);
      check_eq($sformatf("rst_inflight%0d", k), 64'(infl[k]), 64'd0);
      check_eq($sformatf("rst_add_valid%0d", k), 64'(av[k]), 64'd0);
      check_eq($sformatf("rst_add_data%0d", k), ad[k], 64'd0);
      check_eq($sformatf("rst_err%0d", k), 64'(err[k]), 64'd0);
    end
    model_reset();
    req_valid = 4'b0000;
    inj = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: compare at negedge, advance the model at posedge.
  task automatic step();
    int   w [2];
    logic pop [2], orph [2], allow;
    int   r, s;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      pop[k]  = avo[k] && (m_cnt[k] > 0);
      orph[k] = avo[k] && (m_cnt[k] == 0);
      check_eq($sformatf("rsp_valid%0d", k), 64'(rsp[k]),
               pop[k] ? 64'(4'b0001 << m_tag[k][m_head[k]]) : 64'd0);
      if (pop[k]) check_eq($sformatf("rsp_data%0d", k), 64'(rd[k]), 64'(m_res[k][m_head[k]]));
      check_eq($sformatf("inflight%0d", k), 64'(infl[k]), 64'(m_cnt[k]));
      check_eq($sformatf("add_valid%0d", k), 64'(av[k]), 64'(m_av[k]));
      check_eq($sformatf("add_data%0d", k), ad[k], m_ad[k]);
      check_eq($sformatf("err_orphan%0d", k), 64'(err[k]), 64'(m_err[k]));
`ifdef ADDER_ARB_STATS_EN
      check_eq($sformatf("stat_grants%0d", k), 64'(sg[k]), 64'(m_gr[k]));
      check_eq($sformatf("stat_stalls%0d", k), 64'(ss[k]), 64'(m_st[k]));
`endif
      allow = (m_cnt[k] < mi(k)) || avo[k];
      w[k] = -1;
      for (int i = 0; i < NR; i++) begin
        r = (m_rr[k] + i) % NR;
        if (allow && w[k] < 0 && req_valid[r]) w[k] = r;
      end
      check_eq($sformatf("req_ready%0d", k), 64'(rdy[k]), (w[k] >= 0) ? 64'(4'b0001 << w[k]) : 64'd0);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (pop[k]) begin
        m_head[k] = (m_head[k] + 1) % 16;
        m_cnt[k]--;
      end
      if (orph[k]) m_err[k] = 1'b1;
      if (w[k] >= 0) begin
        s = 0;
        for (int i = 0; i < 4; i++) s += ops[w[k]][i];
        m_tag[k][(m_head[k] + m_cnt[k]) % 16] = w[k];
        m_res[k][(m_head[k] + m_cnt[k]) % 16] = to_fp16(s);
        m_cnt[k]++;
        m_rr[k] = (w[k] + 1) % NR;
        m_av[k] = 1'b1;
        m_ad[k] = req_data[w[k]*DW +: DW];
        m_gr[k]++;
      end else begin
        m_av[k] = 1'b0;
        if (req_valid != 4'b0000) m_st[k]++;
      end
    end
    #1;
  endtask

  initial begin
    req_valid = 4'b1111;
    req_data  = '0;
    inj       = 1'b0;
    model_reset();
    do_reset();

    // Round robin with all requesters valid from rr=0.
    set_data();
    req_valid = 4'b1111;
    repeat (8) step();
    req_valid = 4'b0000;
    repeat (8) step();

    // Single op: four FP16 1.0 operands from requester 0.
    for (int i = 0; i < 4; i++) begin
      ops[0][i] = 1;
      req_data[(3-i)*16 +: 16] = 16'h3c00;
    end
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    repeat (6) step();

    // Credit limit: requester 2 always valid.
    set_data();
    req_valid = 4'b0100;
    repeat (20) step();
    req_valid = 4'b0000;
    repeat (8) step();

    // Orphan result with the FIFO empty.
    inj = 1'b1;
    step();
    inj = 1'b0;
    repeat (3) step();

    // Random traffic.
    repeat (300) begin
      req_valid = 4'($urandom_range(0, 15));
      set_data();
      step();
    end
    req_valid = 4'b0000;
    repeat (8) step();

    // Reset in the middle of a burst, then normal operation.
    set_data();
    req_valid = 4'b1111;
    repeat (3) step();
    do_reset();
    set_data();
    req_valid = 4'b1111;
    step();
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
